// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and memory-side bus bundle for mem_arbiter.
// master is the arbiter's view; slave is the caches/memory view.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic [1:0]      icache_command;
  logic [XLEN-1:0] icache_addr;
  logic [1:0]      dcache_command;
  logic [XLEN-1:0] dcache_addr;
  logic [63:0]     dcache_data;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic            icache_grant;
  logic            dcache_grant;
  logic [3:0]      Imem2proc_response;
  logic [3:0]      Dmem2proc_response;
  logic [3:0]      Imem2proc_tag;
  logic [3:0]      Dmem2proc_tag;
  logic [63:0]     Imem2proc_data;
  logic [63:0]     Dmem2proc_data;
  logic [4:0]      outstanding_i;
  logic [4:0]      outstanding_d;
  logic            mem_idle;
  logic            tag_error;

  modport master (
    input  icache_command, icache_addr,
    input  dcache_command, dcache_addr,
    input  dcache_data,
    input  mem2proc_response, mem2proc_data,
    input  mem2proc_tag,
    output proc2mem_command, proc2mem_addr,
    output proc2mem_data,
    output icache_grant, dcache_grant,
    output Imem2proc_response,
    output Dmem2proc_response,
    output Imem2proc_tag, Dmem2proc_tag,
    output Imem2proc_data, Dmem2proc_data,
    output outstanding_i, outstanding_d,
    output mem_idle, tag_error
  );

  modport slave (
    output icache_command, icache_addr,
    output dcache_command, dcache_addr,
    output dcache_data,
    output mem2proc_response, mem2proc_data,
    output mem2proc_tag,
    input  proc2mem_command, proc2mem_addr,
    input  proc2mem_data,
    input  icache_grant, dcache_grant,
    input  Imem2proc_response,
    input  Dmem2proc_response,
    input  Imem2proc_tag, Dmem2proc_tag,
    input  Imem2proc_data, Dmem2proc_data,
    input  outstanding_i, outstanding_d,
    input  mem_idle, tag_error
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: I/D arbiter in front of the single memory bus.
// Data side wins ties; a starvation guard hands icache the bus.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 15
) (
  input logic           clock,
  input logic           reset,
  mem_arbiter_if.master bus
);
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic                i_req;
  logic                d_req;
  logic                grant_i;
  logic                grant_d;
  logic                accept;
  logic                alloc;
  logic                ret_hit;
  logic                ret_d;
  logic                clash;
  logic [3:0]          starve_cnt;
  logic [3:0]          resp;
  logic [3:0]          rtag;
  logic [3:0]          a_idx;
  logic [3:0]          r_idx;
  logic [NUM_TAGS-1:0] valid;
  logic [NUM_TAGS-1:0] is_d;
  logic [4:0]          out_i;
  logic [4:0]          out_d;
  logic                inc_i;
  logic                inc_d;
  logic                dec_i;
  logic                dec_d;
  logic                drop_i;
  logic                drop_d;

  assign resp  = bus.mem2proc_response;
  assign rtag  = bus.mem2proc_tag;
  assign a_idx = resp - 4'd1;
  assign r_idx = rtag - 4'd1;

  assign i_req = bus.icache_command != BUS_NONE;
  assign d_req = bus.dcache_command != BUS_NONE;

  assign grant_i = i_req &&
                   (!d_req || starve_cnt == LIMIT);
  assign grant_d = d_req && !grant_i;

  assign accept = (grant_i || grant_d) && resp != 4'd0;

  always_comb begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = {XLEN{1'b0}};
    unique case (1'b1)
      grant_d: begin
        bus.proc2mem_command = bus.dcache_command;
        bus.proc2mem_addr    = bus.dcache_addr;
      end
      grant_i: begin
        bus.proc2mem_command = bus.icache_command;
        bus.proc2mem_addr    = bus.icache_addr;
      end
      default: ;
    endcase
  end

  assign alloc = accept &&
                 bus.proc2mem_command == BUS_LOAD;

  assign ret_hit = rtag != 4'd0 && valid[r_idx];
  assign ret_d   = is_d[r_idx];

  // An entry freed by a same-cycle return is not a clash
  assign clash = alloc && valid[a_idx] &&
                 !(ret_hit && r_idx == a_idx);

  assign inc_i  = alloc && grant_i;
  assign inc_d  = alloc && grant_d;
  assign dec_i  = ret_hit && !ret_d;
  assign dec_d  = ret_hit && ret_d;
  assign drop_i = clash && !is_d[a_idx];
  assign drop_d = clash && is_d[a_idx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (!i_req || (grant_i && accept)) begin
      starve_cnt <= 4'd0;
    end else if (d_req && grant_d && accept &&
                 starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      is_d  <= '0;
    end else begin
      for (int k = 0; k < NUM_TAGS; k++) begin
        if (alloc && a_idx == 4'(k)) begin
          valid[k] <= 1'b1;
          is_d[k]  <= grant_d;
        end else if (ret_hit && r_idx == 4'(k)) begin
          valid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_i <= 5'd0;
      out_d <= 5'd0;
    end else begin
      out_i <= out_i + 5'(inc_i)
             - 5'(dec_i) - 5'(drop_i);
      out_d <= out_d + 5'(inc_d)
             - 5'(dec_d) - 5'(drop_d);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.tag_error <= 1'b0;
    end else if (clash ||
                 (rtag != 4'd0 && !ret_hit)) begin
      bus.tag_error <= 1'b1;
    end
  end

  assign bus.icache_grant = grant_i;
  assign bus.dcache_grant = grant_d;
  assign bus.proc2mem_data = bus.dcache_data;

  assign bus.Imem2proc_response =
    grant_i ? resp : 4'd0;
  assign bus.Dmem2proc_response =
    grant_d ? resp : 4'd0;

  assign bus.Imem2proc_tag =
    (ret_hit && !ret_d) ? rtag : 4'd0;
  assign bus.Dmem2proc_tag =
    (ret_hit && ret_d) ? rtag : 4'd0;

  assign bus.Imem2proc_data = bus.mem2proc_data;
  assign bus.Dmem2proc_data = bus.mem2proc_data;

  assign bus.outstanding_i = out_i;
  assign bus.outstanding_d = out_d;

  assign bus.mem_idle = out_i == 5'd0 &&
                        out_d == 5'd0 &&
                        !i_req && !d_req;
endmodule
